quadrilatero_tile_sequencer: RTL and testbench
==============================================

Name: quadrilatero_tile_sequencer

Overview:
Command-driven instruction generator that sits in front of the matrix-extension instruction decoder. It accepts one tile-GEMM command (C = sum over K of A_k x B_k) and emits the equivalent stream of encoded 32-bit matrix instructions (MZERO, MLD, MMA/FMMACC, MST) over a valid/ready interface. Its output port feeds the same instruction path as the core's offload interface, behind an arbiter outside this block.

Parameters:
MAX_K, 4, maximum K iterations per command.
ACC_REG, 0, matrix register used as the accumulator.
DATA_REG, 1, matrix register loaded with the A (data) tile.
WGT_REG, 2, matrix register loaded with the B (weight) tile.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  high only in IDLE
cmd_k_i  in  $clog2(MAX_K+1)  K iteration count, 0..MAX_K
cmd_datatype_i  in  quadrilatero_pkg::datatype_t  operand element size
cmd_is_float_i  in  1  floating-point MAC
cmd_a_reg_i  in  5  first scalar register holding A tile addresses
cmd_b_reg_i  in  5  first scalar register holding B tile addresses
cmd_c_reg_i  in  5  scalar register holding the C store address
cmd_stride_reg_i  in  5  scalar register holding the row stride
instr_o  out  32  encoded instruction
instr_valid_o  out  1  instr_o valid
instr_ready_i  in  1  downstream accepts instr_o
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse when the last MST is accepted
err_o  out  1  one-cycle pulse when an illegal command is rejected

Behaviour:
- Reset (asynchronous, any state): state=IDLE, k counter=0, latched command=0. All outputs 0 except cmd_ready_o=1. Any instruction in flight is dropped.
- Command accept: cmd_valid_i && cmd_ready_o latches all cmd fields. State goes to ZERO on the next edge.
- Illegal command: is_float with SIZE_8, or cmd_k_i > MAX_K.
  - The command is accepted but no instruction is emitted.
  - err_o pulses the cycle after accept; state stays IDLE.
- FSM: IDLE -> ZERO -> (K>0 ? LD_A : ST); LD_A -> LD_B -> MAC -> (k==K-1 ? ST : LD_A with k+1); ST -> IDLE.
  - A state advances only on instr_valid_o && instr_ready_i.
- Output timing:
  - instr_valid_o=1 in every state except IDLE.
  - instr_o is a pure function of registered state, so it stays stable while stalled.
  - The first instruction is valid the cycle after accept.
  - Exactly 2+3K instructions per legal command.
  - Throughput is 1 instruction/cycle with instr_ready_i held high.
- Encoding: start from the quadrilatero_instr_pkg constant with wildcard bits forced to 0, then OR in the fields.
  - MZERO: [17:15]=ACC_REG.
  - MLD (LD_A): [9:7]=DATA_REG, [19:15]=(cmd_a_reg+k) mod 32, [24:20]=stride_reg.
  - MLD (LD_B): [9:7]=WGT_REG, [19:15]=(cmd_b_reg+k) mod 32, [24:20]=stride_reg.
  - MLD opcode by datatype: SIZE_8 -> MLD_B, SIZE_16 -> MLD_H, SIZE_32 -> MLD_W.
  - MAC: [17:15]=ACC_REG, [20:18]=WGT_REG, [23:21]=DATA_REG.
  - MAC opcode: int8 -> MMAQA_B, int16 -> MMADA_H, int32 -> MMASA_W, fp16 -> FMMACC_H, fp32 -> FMMACC_S.
  - ST: always MST_W, [9:7]=ACC_REG, [19:15]=c_reg, [24:20]=stride_reg.
- done_o pulses in the cycle the ST handshake completes. cmd_ready_o rises on the following cycle, so no back-to-back accept occurs in the same cycle.
- Scalar register index arithmetic wraps mod 32 (for example, a_reg=31 with k=1 encodes register 0).
- cmd_valid_i while busy is ignored (ready=0). The command must be held by the sender.

Decomposition:
- In quadrilatero_pkg: seq_state_t enum {IDLE, ZERO, LD_A, LD_B, MAC, ST} and the tile_cmd_t struct.
- Opcode constants stay in quadrilatero_instr_pkg, plus field-position localparams (MS_ACC_LSB=15, MS_WGT_LSB=18, MS_DATA_LSB=21, MD_LSB=7, RS1_LSB=15, RS2_LSB=20).
- One combinational sub-module, quadrilatero_instr_encoder: takes (state, latched cmd, k) and returns instr_o.

Test Plan:
- K=1, int8, a=10, b=12, c=14, stride=5, ready always 1. Expect 5 instructions on consecutive cycles:
  - MZERO [17:15]=0.
  - MLD_B [9:7]=1, [19:15]=10, [24:20]=5.
  - MLD_B [9:7]=2, [19:15]=12.
  - MMAQA_B [17:15]=0, [20:18]=2, [23:21]=1.
  - MST_W [9:7]=0, [19:15]=14.
  - done_o pulses on the MST cycle.
- K=3, fp32, a=30 -> 11 instructions, all MAC=FMMACC_S. A loads use rs1 = 30, 31, 0 (wrap check).
- K=2, int16, instr_ready_i random 30% -> instr_o unchanged while stalled, no instruction lost or duplicated, busy_o=1 throughout.
- K=0, fp16 -> MZERO then MST_W only; done_o=1; cmd_ready_o=1 the next cycle.
- fp with SIZE_8, then K=MAX_K+1 -> err_o pulse each time, zero instr_valid_o cycles.
- rst_ni low during LD_B of a K=2 command -> instr_valid_o=0 immediately, cmd_ready_o=1. A fresh command then starts again from MZERO.

Source files
------------

// File: rtl/quadrilatero_instr_pkg.sv
// Matrix-extension opcode constants (wildcard operand bits already zero) and operand field positions.
package quadrilatero_instr_pkg;

  localparam logic [31:0] MLD_B    = 32'h0200_002B;
  localparam logic [31:0] MLD_H    = 32'h0200_102B;
  localparam logic [31:0] MLD_W    = 32'h0200_202B;
  localparam logic [31:0] MST_W    = 32'h0400_202B;
  localparam logic [31:0] MZERO    = 32'h0600_002B;
  localparam logic [31:0] MMAQA_B  = 32'h0800_002B;
  localparam logic [31:0] MMADA_H  = 32'h0800_102B;
  localparam logic [31:0] MMASA_W  = 32'h0800_202B;
  localparam logic [31:0] FMMACC_H = 32'h0A00_102B;
  localparam logic [31:0] FMMACC_S = 32'h0A00_202B;

  localparam int MS_ACC_LSB  = 15;
  localparam int MS_WGT_LSB  = 18;
  localparam int MS_DATA_LSB = 21;
  localparam int MD_LSB      = 7;
  localparam int RS1_LSB     = 15;
  localparam int RS2_LSB     = 20;

endpackage

// File: rtl/quadrilatero_pkg.sv
// Shared types for the tile-GEMM instruction sequencer.
package quadrilatero_pkg;

  typedef enum logic [1:0] {SIZE_8, SIZE_16, SIZE_32} datatype_t;

  typedef enum logic [2:0] {IDLE, ZERO, LD_A, LD_B, MAC, ST} seq_state_t;

  // Wide enough for any sensible MAX_K; the port width is zero-extended into it.
  localparam int CMD_K_W = 8;

  typedef struct packed {
    logic [CMD_K_W-1:0] k;
    datatype_t          datatype;
    logic               is_float;
    logic [4:0]         a_reg;
    logic [4:0]         b_reg;
    logic [4:0]         c_reg;
    logic [4:0]         stride_reg;
  } tile_cmd_t;

endpackage

// File: rtl/quadrilatero_instr_encoder.sv
// Combinational encoder: maps sequencer state, latched command and k index to a 32-bit instruction.
module quadrilatero_instr_encoder
  import quadrilatero_pkg::*;
  import quadrilatero_instr_pkg::*;
#(
  parameter int ACC_REG  = 0,
  parameter int DATA_REG = 1,
  parameter int WGT_REG  = 2
) (
  input  seq_state_t         state_i,
  input  tile_cmd_t          cmd_i,
  input  logic [CMD_K_W-1:0] k_i,
  output logic [31:0]        instr_o
);

  localparam logic [2:0] ACC  = 3'(ACC_REG);
  localparam logic [2:0] DATA = 3'(DATA_REG);
  localparam logic [2:0] WGT  = 3'(WGT_REG);

  logic [4:0]  a_rs1, b_rs1;
  logic [31:0] mld_op, mac_op, stride_f;

  // Five-bit sums wrap the scalar register index modulo 32.
  assign a_rs1    = cmd_i.a_reg + k_i[4:0];
  assign b_rs1    = cmd_i.b_reg + k_i[4:0];
  assign stride_f = 32'(cmd_i.stride_reg) << RS2_LSB;

  always_comb begin
    mld_op = MLD_W;
    mac_op = MMASA_W;
    case (cmd_i.datatype)
      SIZE_8:  begin mld_op = MLD_B; mac_op = MMAQA_B;  end
      SIZE_16: begin mld_op = MLD_H; mac_op = cmd_i.is_float ? FMMACC_H : MMADA_H; end
      default: begin mld_op = MLD_W; mac_op = cmd_i.is_float ? FMMACC_S : MMASA_W; end
    endcase
  end

  always_comb begin
    instr_o = '0;
    case (state_i)
      ZERO: instr_o = MZERO | (32'(ACC) << MS_ACC_LSB);
      LD_A: instr_o = mld_op | (32'(DATA) << MD_LSB) | (32'(a_rs1) << RS1_LSB) | stride_f;
      LD_B: instr_o = mld_op | (32'(WGT) << MD_LSB) | (32'(b_rs1) << RS1_LSB) | stride_f;
      MAC:  instr_o = mac_op | (32'(ACC) << MS_ACC_LSB) | (32'(WGT) << MS_WGT_LSB)
                             | (32'(DATA) << MS_DATA_LSB);
      ST:   instr_o = MST_W | (32'(ACC) << MD_LSB) | (32'(cmd_i.c_reg) << RS1_LSB) | stride_f;
      default: instr_o = '0;
    endcase
  end

endmodule

// File: rtl/quadrilatero_tile_sequencer.sv
// Expands one tile-GEMM command into MZERO, K x (MLD A, MLD B, MAC), MST over valid/ready.
module quadrilatero_tile_sequencer
  import quadrilatero_pkg::*;
#(
  parameter int MAX_K    = 4,
  parameter int ACC_REG  = 0,
  parameter int DATA_REG = 1,
  parameter int WGT_REG  = 2,
  localparam int KW      = $clog2(MAX_K + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [KW-1:0]   cmd_k_i,
  input  datatype_t       cmd_datatype_i,
  input  logic            cmd_is_float_i,
  input  logic [4:0]      cmd_a_reg_i,
  input  logic [4:0]      cmd_b_reg_i,
  input  logic [4:0]      cmd_c_reg_i,
  input  logic [4:0]      cmd_stride_reg_i,
  output logic [31:0]     instr_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  seq_state_t         state_q, state_d;
  tile_cmd_t          cmd_q, cmd_d;
  logic [CMD_K_W-1:0] k_q, k_d;
  logic               err_q, err_d;
  logic               fire, illegal, last_k;

  assign fire    = (state_q != IDLE) && instr_ready_i;
  assign illegal = (cmd_is_float_i && (cmd_datatype_i == SIZE_8))
                || (CMD_K_W'(cmd_k_i) > CMD_K_W'(MAX_K));
  assign last_k  = (k_q == (cmd_q.k - CMD_K_W'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    k_d     = k_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        cmd_d.k          = CMD_K_W'(cmd_k_i);
        cmd_d.datatype   = cmd_datatype_i;
        cmd_d.is_float   = cmd_is_float_i;
        cmd_d.a_reg      = cmd_a_reg_i;
        cmd_d.b_reg      = cmd_b_reg_i;
        cmd_d.c_reg      = cmd_c_reg_i;
        cmd_d.stride_reg = cmd_stride_reg_i;
        // Illegal commands are consumed and flagged but never leave IDLE.
        if (illegal) begin
          err_d = 1'b1;
        end else begin
          state_d = ZERO;
          k_d     = '0;
        end
      end
      ZERO: if (fire) state_d = (cmd_q.k != '0) ? LD_A : ST;
      LD_A: if (fire) state_d = LD_B;
      LD_B: if (fire) state_d = MAC;
      MAC:  if (fire) begin
        if (last_k) begin
          state_d = ST;
        end else begin
          state_d = LD_A;
          k_d     = k_q + CMD_K_W'(1);
        end
      end
      ST:   if (fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o   = (state_q == IDLE);
    busy_o        = (state_q != IDLE);
    instr_valid_o = (state_q != IDLE);
    done_o        = (state_q == ST) && instr_ready_i;
    err_o         = err_q;
  end

  quadrilatero_instr_encoder #(
    .ACC_REG  (ACC_REG),
    .DATA_REG (DATA_REG),
    .WGT_REG  (WGT_REG)
  ) u_encoder (
    .state_i  (state_q),
    .cmd_i    (cmd_q),
    .k_i      (k_q),
    .instr_o  (instr_o)
  );

endmodule

// File: tb/tb_quadrilatero_tile_sequencer.sv
// Directed self-checking bench for the tile-GEMM instruction sequencer.
module tb_quadrilatero_tile_sequencer;
  import quadrilatero_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [2:0]  cmd_k_i = '0;
  datatype_t   cmd_datatype_i = SIZE_8;
  logic        cmd_is_float_i = 1'b0;
  logic [4:0]  cmd_a_reg_i = '0, cmd_b_reg_i = '0, cmd_c_reg_i = '0, cmd_stride_reg_i = '0;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        busy_o, done_o, err_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  quadrilatero_tile_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_k_i(cmd_k_i),
    .cmd_datatype_i(cmd_datatype_i), .cmd_is_float_i(cmd_is_float_i),
    .cmd_a_reg_i(cmd_a_reg_i), .cmd_b_reg_i(cmd_b_reg_i), .cmd_c_reg_i(cmd_c_reg_i),
    .cmd_stride_reg_i(cmd_stride_reg_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ld(input logic [31:0] opc, input int md, input int rs1, input int rs2);
    return opc | (32'(md) << 7) | (32'(rs1 % 32) << 15) | (32'(rs2) << 20);
  endfunction

  task automatic build(input int k, input datatype_t dt, input logic fl,
                       input int a, input int b, input int c, input int s);
    logic [31:0] mld, mac;
    case (dt)
      SIZE_8:  begin mld = 32'h0200002B; mac = 32'h0800002B; end
      SIZE_16: begin mld = 32'h0200102B; mac = fl ? 32'h0A00102B : 32'h0800102B; end
      default: begin mld = 32'h0200202B; mac = fl ? 32'h0A00202B : 32'h0800202B; end
    endcase
    exp_q.delete();
    exp_q.push_back(32'h0600002B);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(ld(mld, 1, a + i, s));
      exp_q.push_back(ld(mld, 2, b + i, s));
      exp_q.push_back(mac | 32'h00280000);
    end
    exp_q.push_back(32'h0400202B | (32'(c) << 15) | (32'(s) << 20));
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input string tag, input logic [2:0] k, input datatype_t dt, input logic fl,
                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] s);
    cmd_k_i = k; cmd_datatype_i = dt; cmd_is_float_i = fl;
    cmd_a_reg_i = a; cmd_b_reg_i = b; cmd_c_reg_i = c; cmd_stride_reg_i = s;
    cmd_valid_i = 1'b1;
    #1;
    chk($sformatf("%s cmd_ready", tag), 32'(cmd_ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic collect(input string tag, input int ready_pct);
    int got = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [31:0] held = '0;
    logic xfer;
    while (got < exp_q.size() && cyc < 400) begin
      instr_ready_i = ($urandom_range(99, 0) < ready_pct);
      #1;
      chk($sformatf("%s valid c%0d", tag, cyc), 32'(instr_valid_o), 32'd1);
      chk($sformatf("%s busy c%0d", tag, cyc), 32'(busy_o), 32'd1);
      if (stalled) chk($sformatf("%s stable c%0d", tag, cyc), instr_o, held);
      xfer = instr_valid_o && instr_ready_i;
      chk($sformatf("%s done c%0d", tag, cyc), 32'(done_o),
          32'(xfer && (got == exp_q.size() - 1)));
      if (xfer) begin
        chk($sformatf("%s instr%0d", tag, got), instr_o, exp_q[got]);
        got++;
        stalled = 1'b0;
      end else begin
        stalled = instr_valid_o;
        held = instr_o;
      end
      @(negedge clk_i);
      cyc++;
    end
    instr_ready_i = 1'b0;
    chk($sformatf("%s count", tag), 32'(got), 32'(exp_q.size()));
    if (ready_pct >= 100) chk($sformatf("%s cycles", tag), 32'(cyc), 32'(exp_q.size()));
    #1;
    chk($sformatf("%s end cmd_ready", tag), 32'(cmd_ready_o), 32'd1);
    chk($sformatf("%s end valid", tag), 32'(instr_valid_o), 32'd0);
    chk($sformatf("%s end busy", tag), 32'(busy_o), 32'd0);
    @(negedge clk_i);
  endtask

  initial begin
    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst valid", 32'(instr_valid_o), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst err", 32'(err_o), 32'd0);
    chk("rst instr", instr_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // K=1 int8, fully hand-encoded
    exp_q = '{32'h0600002B, 32'h025500AB, 32'h0256012B, 32'h0828002B, 32'h0457202B};
    send("k1_int8", 3'd1, SIZE_8, 1'b0, 5'd10, 5'd12, 5'd14, 5'd5);
    collect("k1_int8", 100);

    // K=3 fp32 with A register wrap 30,31,0
    build(3, SIZE_32, 1'b1, 30, 3, 7, 9);
    send("k3_fp32", 3'd3, SIZE_32, 1'b1, 5'd30, 5'd3, 5'd7, 5'd9);
    collect("k3_fp32", 100);

    // K=2 int16 with sparse ready
    build(2, SIZE_16, 1'b0, 4, 20, 1, 2);
    send("k2_int16", 3'd2, SIZE_16, 1'b0, 5'd4, 5'd20, 5'd1, 5'd2);
    collect("k2_int16", 30);

    // K=0 fp16
    exp_q = '{32'h0600002B, 32'h0400202B | (32'd17 << 15) | (32'd3 << 20)};
    send("k0_fp16", 3'd0, SIZE_16, 1'b1, 5'd1, 5'd2, 5'd17, 5'd3);
    collect("k0_fp16", 100);

    // Illegal: float with 8-bit elements
    send("ill_fp8", 3'd1, SIZE_8, 1'b1, 5'd1, 5'd2, 5'd3, 5'd4);
    #1;
    chk("ill_fp8 err", 32'(err_o), 32'd1);
    chk("ill_fp8 valid", 32'(instr_valid_o), 32'd0);
    chk("ill_fp8 cmd_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk_i);
    #1;
    chk("ill_fp8 err off", 32'(err_o), 32'd0);
    chk("ill_fp8 valid2", 32'(instr_valid_o), 32'd0);
    @(negedge clk_i);

    // Illegal: K = MAX_K+1
    send("ill_k5", 3'd5, SIZE_32, 1'b0, 5'd1, 5'd2, 5'd3, 5'd4);
    #1;
    chk("ill_k5 err", 32'(err_o), 32'd1);
    chk("ill_k5 valid", 32'(instr_valid_o), 32'd0);
    chk("ill_k5 busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    #1;
    chk("ill_k5 err off", 32'(err_o), 32'd0);
    chk("ill_k5 valid2", 32'(instr_valid_o), 32'd0);
    @(negedge clk_i);

    // Reset while in LD_B of a K=2 command
    send("rst_mid", 3'd2, SIZE_8, 1'b0, 5'd1, 5'd2, 5'd3, 5'd4);
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_mid in LD_B", instr_o, ld(32'h0200002B, 2, 2, 4));
    instr_ready_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid valid", 32'(instr_valid_o), 32'd0);
    chk("rst_mid cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_mid busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    build(1, SIZE_32, 1'b0, 8, 9, 10, 11);
    send("after_rst", 3'd1, SIZE_32, 1'b0, 5'd8, 5'd9, 5'd10, 5'd11);
    collect("after_rst", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
